// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-position shift controller around an external
// single-position 16-bit shifter. It accepts an operand, op and amount, then
// iterates the shifter once per clock until the requested count is applied.
// Optional feature macro: SHIFT_SEQ_EARLY_EXIT_EN. When it is defined, the
// sequence ends as soon as the shifter output equals the working value
// (a fixed point).
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] sh_in,
  output logic [1:0]       sh_shift,
  input  logic [WIDTH-1:0] sh_sout
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] work_reg, work_next;
  logic [AMT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       op_reg, op_next;
  logic             accept;
  logic             last_iter;

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  // Bitwise equality between the shifter output and the working value.
  // When every bit matches, further iterations cannot change the result.
  logic [WIDTH-1:0] bit_eq;
  logic             fixed_point;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_eq
    assign bit_eq[gi] = sh_sout[gi] ~^ work_reg[gi];
  end

  assign fixed_point = &bit_eq;
  assign last_iter   = (cnt_reg == AMT_W'(1)) || fixed_point;
`else
  assign last_iter   = (cnt_reg == AMT_W'(1));
`endif

  // Status and shifter-drive outputs, all decoded from registered state.
  assign ready    = (state_reg == IDLE) || (state_reg == DONE);
  assign busy     = (state_reg == SHIFT);
  assign done     = (state_reg == DONE);
  assign result   = work_reg;
  assign sh_in    = work_reg;
  assign sh_shift = busy ? op_reg : 2'b00;
  assign accept   = start && ready;

  // State and datapath registers. An asynchronous reset clears everything,
  // even in the middle of a sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      cnt_reg   <= '0;
      op_reg    <= 2'b00;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
    end
  end

  // Next-state and datapath update. A zero amount or the pass op completes
  // on the accept edge itself, with no shifter iteration.
  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (accept) begin
          work_next = operand;
          op_next   = op;
          cnt_next  = amount;
          if ((amount == '0) || (op == 2'b00)) begin
            state_next = DONE;
          end else begin
            state_next = SHIFT;
          end
        end else if (state_reg == DONE) begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        work_next = sh_sout;
        cnt_next  = cnt_reg - AMT_W'(1);
        if (last_iter) begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-position shift controller wrapped around the existing single-position 16-bit shifter.
- Accepts an operand, a shift op and a shift amount, then iterates the external shifter once per clock until the requested number of positions is applied.
- Returns the result with a done pulse.
- Sits between instruction decode/datapath control and the shifter instance, and owns the shifter's in/shift inputs.

Parameters:
- WIDTH, 16, operand/result width; must match the shifter.
- AMT_W, 4, width of the shift-amount field; maximum amount 2^AMT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when ready=1.
- operand  input  WIDTH  value to shift, captured on accept.
- op  input  2  shifter code, captured on accept: 00 pass, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1 (MSB replicated).
- amount  input  AMT_W  number of positions, captured on accept.
- ready  output  1  high when a start will be accepted (state IDLE or DONE).
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  working register; holds final value until next accept.
- sh_in  output  WIDTH  drives shifter in; equals working register.
- sh_shift  output  2  drives shifter shift; captured op while in SHIFT, 00 otherwise.
- sh_sout  input  WIDTH  shifter sout, combinational return.

Behaviour:
- Interface: single clock clk; reset_n asynchronous, active-low.
- States are IDLE, SHIFT and DONE.
- Reset (async, any state, including mid-shift):
  - state=IDLE, work=0, cnt=0, op_q=00.
  - Outputs: done=0, busy=0, ready=1, result=0, sh_shift=00.
- Accept: rising edge with start=1 and ready=1.
  - work<=operand, op_q<=op, cnt<=amount.
  - If amount==0 or op==00: go to DONE. result=operand, visible after the same edge.
  - Otherwise go to SHIFT.
- SHIFT, each edge:
  - work<=sh_sout and cnt<=cnt-1.
  - If cnt==1 at that edge, go to DONE; else stay in SHIFT.
- Latency: N = amount (N≥1, op≠00) means done is high in the cycle after the Nth edge following the accept edge. Exactly N shifter iterations.
- DONE: done=1 for exactly one cycle, then IDLE unless a new start is accepted in that cycle. Back-to-back accept from DONE is legal, giving zero idle cycles.
- start while busy=1 is ignored; captured fields are unaffected.
- operand, op and amount may change freely after the accept edge.
- Arithmetic: no wrap. amount=15 with LSL on WIDTH=16 leaves only bit0 moved to bit15. Bits shifted out are lost; there is no carry output.
- result equals the working register at all times. It is stable and valid from the done cycle until the next accept edge.

Optional Feature:
- Macro: SHIFT_SEQ_EARLY_EXIT_EN.
- Defined: in SHIFT, if sh_sout==work at an edge (fixed point: zero for LSL/LSR; all-zeros or all-ones for ASR), go to DONE at that edge regardless of cnt.
  - work is unchanged and the result is identical to the full sequence.
  - Latency becomes min(N, first fixed-point edge).
- Not defined: always exactly N iterations.
- Result values are identical either way; only timing differs.

Test Plan:
- LSL: operand=0x0001, op=01, amount=4 -> done 4 edges after accept, result=0x0010, busy high 4 cycles.
- ASR: operand=0x8000, op=11, amount=3 -> result=0xF000.
- LSR: operand=0x8000, op=10, amount=15 -> result=0x0001 after 15 edges.
- Zero amount: amount=0, operand=0x1234, op=01 -> done in the cycle after accept, result=0x1234.
- Pass op: op=00, amount=7, operand=0xBEEF -> done in the cycle after accept, result=0xBEEF, sh_shift stays 00.
- Control and reset:
  - start pulsed with new operand mid-SHIFT -> ignored, original result delivered.
  - Back-to-back start in the DONE cycle -> accepted.
  - reset_n low mid-SHIFT -> immediate IDLE, result=0, done=0, no done pulse.
- Early exit: LSR, operand=0x0003, amount=15 -> with SHIFT_SEQ_EARLY_EXIT_EN, done after 3 edges (0x0001, 0x0000, fixed point); without it, done after 15 edges. result=0x0000 in both cases.
